// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7789-style SPI display sink: command codes and decoder states.
package lcd_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        CMD,
        CASET,
        RASET,
        RAMWR,
        IGNORE
    } lcd_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises the bus pins, detects rising spi_clk edges
// and assembles MSB-first bytes tagged with the dc level seen on the final bit.
module spi_byte_rx #(
    parameter bit c_clk_polarity = 1'b1
) (
    input  logic       clk,
    input  logic       resn,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic       spi_resn,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       soft_rst
);

    logic [1:0] csn_sync, sclk_sync, mosi_sync, dc_sync, resn_sync;
    logic       sclk_prev;
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       rise;

    assign rise     = sclk_sync[1] & ~sclk_prev;
    assign soft_rst = ~resn_sync[1];

    // Clock synchroniser resets to the idle level so no phantom edge follows reset release.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            csn_sync   <= '1;
            sclk_sync  <= {2{c_clk_polarity}};
            sclk_prev  <= c_clk_polarity;
            mosi_sync  <= '0;
            dc_sync    <= '0;
            resn_sync  <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            csn_sync   <= {csn_sync[0], spi_csn};
            sclk_sync  <= {sclk_sync[0], spi_clk};
            sclk_prev  <= sclk_sync[1];
            mosi_sync  <= {mosi_sync[0], spi_mosi};
            dc_sync    <= {dc_sync[0], spi_dc};
            resn_sync  <= {resn_sync[0], spi_resn};
            byte_valid <= 1'b0;
            if (soft_rst || csn_sync[1]) begin
                bit_cnt <= '0;
            end else if (rise) begin
                shift   <= {shift[5:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_sync[1]};
                    byte_dc    <= dc_sync[1];
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_sink.sv
// ST7789-compatible SPI display sink: decodes CASET/RASET/RAMWR and emits addressed
// RGB565 pixel writes for mirroring the panel image into a framebuffer.
module lcd_spi_sink
    import lcd_pkg::*;
#(
    parameter int c_x_size       = 240,
    parameter int c_y_size       = 240,
    parameter int c_x_bits       = $clog2(c_x_size),
    parameter int c_y_bits       = $clog2(c_y_size),
    parameter bit c_clk_polarity = 1'b1
) (
    input  logic                clk,
    input  logic                resn,
    input  logic                spi_csn,
    input  logic                spi_clk,
    input  logic                spi_mosi,
    input  logic                spi_dc,
    input  logic                spi_resn,
    output logic                pixel_we,
    output logic [c_x_bits-1:0] pixel_x,
    output logic [c_y_bits-1:0] pixel_y,
    output logic [15:0]         pixel_color,
    output logic                cmd_strobe,
    output logic [7:0]          cmd_byte,
    output logic                frame_start
);

    localparam logic [c_x_bits-1:0] X_END = c_x_bits'(c_x_size - 1);
    localparam logic [c_y_bits-1:0] Y_END = c_y_bits'(c_y_size - 1);
    localparam logic [c_x_bits:0]   X_LIM = (c_x_bits + 1)'(c_x_size);
    localparam logic [c_y_bits:0]   Y_LIM = (c_y_bits + 1)'(c_y_size);

    logic       rx_valid, rx_dc, soft_rst;
    logic [7:0] rx_byte;

    spi_byte_rx #(.c_clk_polarity(c_clk_polarity)) u_rx (
        .clk       (clk),
        .resn      (resn),
        .spi_csn   (spi_csn),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_dc    (spi_dc),
        .spi_resn  (spi_resn),
        .byte_valid(rx_valid),
        .byte_data (rx_byte),
        .byte_dc   (rx_dc),
        .soft_rst  (soft_rst)
    );

    lcd_state_t          state_q, state_d;
    logic [c_x_bits-1:0] xs, xe, cur_x, new_xs, new_xe, raw_xe;
    logic [c_y_bits-1:0] ys, ye, cur_y, new_ys, new_ye, raw_ye;
    logic [23:0]         arg_buf;
    logic [1:0]          arg_cnt;
    logic                hi_flag, in_range;
    logic [7:0]          hi_byte;
    logic [15:0]         arg_s, arg_e;

    // Start is the first two buffered bytes; end is the third plus the byte arriving now.
    assign arg_s    = arg_buf[23:8];
    assign arg_e    = {arg_buf[7:0], rx_byte};
    assign new_xs   = arg_s[c_x_bits-1:0];
    assign raw_xe   = arg_e[c_x_bits-1:0];
    assign new_xe   = (raw_xe < new_xs) ? new_xs : raw_xe;
    assign new_ys   = arg_s[c_y_bits-1:0];
    assign raw_ye   = arg_e[c_y_bits-1:0];
    assign new_ye   = (raw_ye < new_ys) ? new_ys : raw_ye;
    assign in_range = ({1'b0, cur_x} < X_LIM) && ({1'b0, cur_y} < Y_LIM);

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) state_q <= CMD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (soft_rst) begin
            state_d = CMD;
        end else if (rx_valid && !rx_dc) begin
            case (rx_byte)
                CMD_CASET:   state_d = CASET;
                CMD_RASET:   state_d = RASET;
                CMD_RAMWR:   state_d = RAMWR;
                CMD_SWRESET: state_d = CMD;
                default:     state_d = IGNORE;
            endcase
        end else if (rx_valid && (state_q == CASET || state_q == RASET) && arg_cnt == 2'd3) begin
            state_d = CMD;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            pixel_we <= 1'b0; pixel_x <= '0; pixel_y <= '0; pixel_color <= '0;
            cmd_strobe <= 1'b0; cmd_byte <= '0; frame_start <= 1'b0;
            xs <= '0; xe <= X_END; ys <= '0; ye <= Y_END; cur_x <= '0; cur_y <= '0;
            arg_buf <= '0; arg_cnt <= '0; hi_flag <= 1'b0; hi_byte <= '0;
        end else if (soft_rst) begin
            pixel_we <= 1'b0; pixel_x <= '0; pixel_y <= '0; pixel_color <= '0;
            cmd_strobe <= 1'b0; cmd_byte <= '0; frame_start <= 1'b0;
            xs <= '0; xe <= X_END; ys <= '0; ye <= Y_END; cur_x <= '0; cur_y <= '0;
            arg_buf <= '0; arg_cnt <= '0; hi_flag <= 1'b0; hi_byte <= '0;
        end else begin
            pixel_we    <= 1'b0;
            cmd_strobe  <= 1'b0;
            frame_start <= 1'b0;
            if (rx_valid && !rx_dc) begin
                // Any command byte discards partial arguments or a half-received pixel.
                cmd_strobe <= 1'b1;
                cmd_byte   <= rx_byte;
                arg_cnt    <= '0;
                hi_flag    <= 1'b0;
                if (rx_byte == CMD_RAMWR) begin
                    frame_start <= 1'b1;
                    cur_x       <= xs;
                    cur_y       <= ys;
                end
                if (rx_byte == CMD_SWRESET) begin
                    xs <= '0; xe <= X_END; ys <= '0; ye <= Y_END;
                end
            end else if (rx_valid) begin
                case (state_q)
                    CASET, RASET: begin
                        arg_buf <= {arg_buf[15:0], rx_byte};
                        arg_cnt <= arg_cnt + 2'd1;
                        if (arg_cnt == 2'd3 && state_q == CASET) begin
                            xs <= new_xs;
                            xe <= new_xe;
                        end
                        if (arg_cnt == 2'd3 && state_q == RASET) begin
                            ys <= new_ys;
                            ye <= new_ye;
                        end
                    end
                    RAMWR: begin
                        hi_flag <= ~hi_flag;
                        if (!hi_flag) begin
                            hi_byte <= rx_byte;
                        end else begin
                            if (in_range) begin
                                pixel_we    <= 1'b1;
                                pixel_x     <= cur_x;
                                pixel_y     <= cur_y;
                                pixel_color <= {hi_byte, rx_byte};
                            end
                            if (cur_x == xe) begin
                                cur_x <= xs;
                                cur_y <= (cur_y == ye) ? ys : cur_y + 1'b1;
                            end else begin
                                cur_x <= cur_x + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
